pw_bit_rx: RTL and testbench

Pulse-width bit receiver: the downstream counterpart of the `axi_pw_bit` transmitter. It samples one serial `rxd` line and measures the high time of each bit. Each high time is sliced against a programmable threshold to recover a 0 or 1. Recovered bits are packed into DATA_WIDTH-bit words and presented on a valid/ready stream. A long low gap marks the end of a frame; any partial word is then flushed with `m_last`.

---
 rtl/pw_bit_pkg.sv | 12 +
 rtl/pw_bit_sync.sv | 25 ++
 rtl/pw_bit_rx.sv | 151 +++++++++++++++
 tb/tb_pw_bit_rx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_bit_pkg.sv
// pw_bit_pkg: receiver state type and pulse-width timing defaults shared with the transmitter
package pw_bit_pkg;
  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    WAIT_LOW
  } pw_rx_state_t;
  localparam int PW_PERIOD = 125;
  localparam int PW_T0H = 40;
  localparam int PW_T1H = 80;
endpackage

// File: rtl/pw_bit_sync.sv
// pw_bit_sync: multi-flop synchronizer for an asynchronous line with rise/fall strobes
module pw_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] ff;
  logic prev;
  always_ff @(posedge aclk)
    if (!aresetn) begin
      ff <= '0;
      prev <= 1'b0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1];
    end
  assign q = ff[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/pw_bit_rx.sv
// pw_bit_rx: pulse-width serial receiver; slices each high time into a bit and packs bits into stream words
module pw_bit_rx
  import pw_bit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  localparam int NBITS_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  rxd,
  input  logic                  cfg_enable,
  input  logic [CNT_WIDTH-1:0]  cfg_threshold,
  input  logic [CNT_WIDTH-1:0]  cfg_min_high,
  input  logic [CNT_WIDTH-1:0]  cfg_gap,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [NBITS_W-1:0]    m_nbits,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_glitch,
  output logic                  err_stuck,
  output logic                  err_overflow,
  output logic                  busy
);
  pw_rx_state_t state, state_n;
  logic rxd_s, rise, fall, bit_v;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n, ed, ed_n;
  logic [NBITS_W-1:0] nb, nb_n, en, en_n;
  logic el, el_n, emit, emit_n, glitch_n, stuck_n;

  pw_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .aclk(aclk),
    .aresetn(aresetn),
    .d(rxd),
    .q(rxd_s),
    .rise(rise),
    .fall(fall)
  );

  assign bit_v = cnt >= cfg_threshold;
  assign busy = state != IDLE;

  always_comb begin
    state_n = state;
    cnt_n = &cnt ? cnt : cnt + CNT_WIDTH'(1);
    sh_n = sh;
    nb_n = nb;
    emit_n = 1'b0;
    ed_n = ed;
    en_n = en;
    el_n = el;
    glitch_n = 1'b0;
    stuck_n = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = HIGH;
        cnt_n = CNT_WIDTH'(1);
      end
      HIGH: if (fall) begin
        state_n = LOW;
        cnt_n = CNT_WIDTH'(1);
        if (cnt < cfg_min_high) glitch_n = 1'b1;
        else if (nb == NBITS_W'(DATA_WIDTH - 1)) begin
          emit_n = 1'b1;
          ed_n = {sh[DATA_WIDTH-2:0], bit_v};
          en_n = NBITS_W'(DATA_WIDTH);
          el_n = 1'b0;
          sh_n = '0;
          nb_n = '0;
        end else begin
          sh_n = {sh[DATA_WIDTH-2:0], bit_v};
          nb_n = nb + NBITS_W'(1);
        end
      end else if (cnt >= cfg_gap) begin
        state_n = WAIT_LOW;
        stuck_n = 1'b1;
        sh_n = '0;
        nb_n = '0;
      end
      LOW: if (rise) begin
        state_n = HIGH;
        cnt_n = CNT_WIDTH'(1);
      end else if (cnt >= cfg_gap) begin
        state_n = IDLE;
        emit_n = nb != '0;
        ed_n = sh;
        en_n = nb;
        el_n = 1'b1;
        sh_n = '0;
        nb_n = '0;
      end
      WAIT_LOW: if (fall || !rxd_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // disabling mid-frame silently drops the partial word
    if (!cfg_enable) begin
      state_n = IDLE;
      sh_n = '0;
      nb_n = '0;
      emit_n = 1'b0;
      glitch_n = 1'b0;
      stuck_n = 1'b0;
    end
  end

  always_ff @(posedge aclk)
    if (!aresetn) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      nb <= '0;
      emit <= 1'b0;
      ed <= '0;
      en <= '0;
      el <= 1'b0;
      err_glitch <= 1'b0;
      err_stuck <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      nb <= nb_n;
      emit <= emit_n;
      ed <= ed_n;
      en <= en_n;
      el <= el_n;
      err_glitch <= glitch_n;
      err_stuck <= stuck_n;
    end

  // single-entry output register; a word arriving while it is full and not draining is dropped
  always_ff @(posedge aclk)
    if (!aresetn) begin
      m_data <= '0;
      m_nbits <= '0;
      m_last <= 1'b0;
      m_valid <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= emit && m_valid && !m_ready;
      if (emit && (!m_valid || m_ready)) begin
        m_data <= ed;
        m_nbits <= en;
        m_last <= el;
        m_valid <= 1'b1;
      end else if (m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pw_bit_rx.sv
// tb_pw_bit_rx: directed table, corner sequences and a randomized pulse stream checked against a bit-queue model
module tb_pw_bit_rx;
  import pw_bit_pkg::*;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SS = 2;

  typedef struct {
    logic [31:0] data;
    int nbits;
    logic last;
  } word_t;
  typedef struct {
    int n;
    logic [31:0] bits;
    logic [31:0] data;
    int nbits;
    logic last;
  } vec_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic rxd = 1'b0;
  logic cfg_enable = 1'b0;
  logic m_ready = 1'b0;
  logic [CW-1:0] cfg_threshold = '0;
  logic [CW-1:0] cfg_min_high = '0;
  logic [CW-1:0] cfg_gap = '0;
  logic [DW-1:0] m_data;
  logic [5:0] m_nbits;
  logic m_last, m_valid, err_glitch, err_stuck, err_overflow, busy;
  logic rand_ready = 1'b0;
  word_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_glitch = 0;
  int n_stuck = 0;
  int n_ovf = 0;
  int exp_glitch = 0;
  int exp_stuck = 0;
  int exp_ovf = 0;

  always #5 aclk = ~aclk;

  pw_bit_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .rxd(rxd),
    .cfg_enable(cfg_enable),
    .cfg_threshold(cfg_threshold),
    .cfg_min_high(cfg_min_high),
    .cfg_gap(cfg_gap),
    .m_data(m_data),
    .m_nbits(m_nbits),
    .m_last(m_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .err_glitch(err_glitch),
    .err_stuck(err_stuck),
    .err_overflow(err_overflow),
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input int n, input logic l);
    word_t w;
    w.data = d;
    w.nbits = n;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic pulse(input int h, input int l);
    rxd = 1'b1;
    repeat (h) @(posedge aclk);
    #1 rxd = 1'b0;
    repeat (l) @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--)
      pulse(v[i] ? PW_T1H : PW_T0H, v[i] ? PW_PERIOD - PW_T1H : PW_PERIOD - PW_T0H);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic monitor();
    logic held = 1'b0;
    logic [31:0] hd = '0;
    logic [5:0] hn = '0;
    logic hl = 1'b0;
    word_t w;
    forever begin
      @(negedge aclk);
      if (!aresetn) held = 1'b0;
      else begin
        if (held) begin
          check("hold_valid", 64'(m_valid), 64'(1));
          check("hold_data", 64'(m_data), 64'(hd));
          check("hold_nbits", 64'(m_nbits), 64'(hn));
          check("hold_last", 64'(m_last), 64'(hl));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got data %h nbits %0d last %0d, want no word", m_data, m_nbits, m_last);
          end else begin
            w = exp_q.pop_front();
            check("word_data", 64'(m_data), 64'(w.data));
            check("word_nbits", 64'(m_nbits), 64'(w.nbits));
            check("word_last", 64'(m_last), 64'(w.last));
          end
        end
        held = m_valid && !m_ready;
        hd = m_data;
        hn = m_nbits;
        hl = m_last;
        if (err_glitch) n_glitch++;
        if (err_stuck) n_stuck++;
        if (err_overflow) n_ovf++;
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    vec_t tbl[6];
    int bits[$];
    int h, l, r, lat, thr, mn, gp;
    logic [31:0] acc;
    tbl[0] = '{32, 32'hA5C30F81, 32'hA5C30F81, 32, 1'b0};
    tbl[1] = '{5, 32'h16, 32'h16, 5, 1'b1};
    tbl[2] = '{8, 32'hFF, 32'hFF, 8, 1'b1};
    tbl[3] = '{1, 32'h0, 32'h0, 1, 1'b1};
    tbl[4] = '{12, 32'hABC, 32'hABC, 12, 1'b1};
    tbl[5] = '{32, 32'h00000001, 32'h00000001, 32, 1'b0};
    fork
      monitor();
      ready_gen();
    join_none
    cfg_threshold = 16'd60;
    cfg_min_high = 16'd10;
    cfg_gap = 16'd500;
    cfg_enable = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_flags", 64'({m_valid, m_last, m_nbits, err_glitch, err_stuck, err_overflow, busy}), 64'(0));
    check("reset_data", 64'(m_data), 64'(0));
    aresetn = 1'b1;
    idle(5);

    foreach (tbl[i]) begin
      push_exp(tbl[i].data, tbl[i].nbits, tbl[i].last);
      send_bits(tbl[i].n, tbl[i].bits);
      idle(520);
      drain($sformatf("table_%0d_drain", i));
    end

    push_exp(32'h12345679, 32, 1'b0);
    send_bits(31, 32'h12345679 >> 1);
    rxd = 1'b1;
    repeat (PW_T1H) @(posedge aclk);
    #1 rxd = 1'b0;
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    check("word_latency", 64'(lat), 64'(SS + 2));
    idle(100);
    drain("latency_drain");

    push_exp(32'hD, 4, 1'b1);
    send_bits(2, 32'b11);
    pulse(4, 121);
    exp_glitch++;
    send_bits(2, 32'b01);
    idle(520);
    drain("glitch_drain");
    check("glitch_pulses", 64'(n_glitch), 64'(exp_glitch));

    send_bits(3, 32'b101);
    rxd = 1'b1;
    repeat (600) @(posedge aclk);
    #1 rxd = 1'b0;
    exp_stuck++;
    idle(600);
    check("stuck_pulses", 64'(n_stuck), 64'(exp_stuck));
    check("stuck_idle", 64'(busy), 64'(0));
    push_exp(32'h13, 5, 1'b1);
    send_bits(5, 32'b10011);
    idle(520);
    drain("after_stuck_drain");

    send_bits(6, 32'h2D);
    cfg_enable = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("disable_busy", 64'(busy), 64'(0));
    cfg_enable = 1'b1;
    idle(520);

    m_ready = 1'b0;
    send_bits(32, 32'hDEADBEEF);
    send_bits(32, 32'h0F0F1234);
    idle(20);
    check("ovf_valid", 64'(m_valid), 64'(1));
    check("ovf_data", 64'(m_data), 64'(32'hDEADBEEF));
    exp_ovf++;
    check("overflow_pulses", 64'(n_ovf), 64'(exp_ovf));
    push_exp(32'hDEADBEEF, 32, 1'b0);
    m_ready = 1'b1;
    idle(520);
    drain("overflow_drain");

    m_ready = 1'b0;
    send_bits(32, 32'hCAFEF00D);
    send_bits(12, 32'hABC);
    check("pre_reset_busy", 64'(busy), 64'(1));
    check("pre_reset_valid", 64'(m_valid), 64'(1));
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("midreset_flags", 64'({m_valid, m_last, m_nbits, err_glitch, err_stuck, err_overflow, busy}), 64'(0));
    check("midreset_data", 64'(m_data), 64'(0));
    aresetn = 1'b1;
    m_ready = 1'b1;
    push_exp(32'h5A5AC3C3, 32, 1'b0);
    send_bits(32, 32'h5A5AC3C3);
    idle(520);
    drain("after_reset_drain");

    thr = $urandom_range(15, 40);
    mn = $urandom_range(3, 10);
    gp = 100;
    cfg_threshold = CW'(thr);
    cfg_min_high = CW'(mn);
    cfg_gap = CW'(gp);
    rand_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      h = r == 0 ? mn - 1 : r == 1 ? mn : r == 2 ? thr - 1 : r == 3 ? thr : $urandom_range(1, 90);
      l = $urandom_range(0, 9) == 0 ? $urandom_range(110, 140) : $urandom_range(2, 40);
      if (h < mn) exp_glitch++;
      else bits.push_back(h >= thr ? 1 : 0);
      if (bits.size() == DW || (l > gp && bits.size() > 0)) begin
        acc = '0;
        foreach (bits[j]) acc = (acc << 1) | 32'(bits[j]);
        push_exp(acc, bits.size(), bits.size() != DW);
        bits.delete();
      end
      pulse(h, l);
    end
    if (bits.size() > 0) begin
      acc = '0;
      foreach (bits[j]) acc = (acc << 1) | 32'(bits[j]);
      push_exp(acc, bits.size(), 1'b1);
    end
    idle(200);
    drain("random_drain");
    rand_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #2 m_ready = 1'b1;
    idle(10);

    check("final_glitch", 64'(n_glitch), 64'(exp_glitch));
    check("final_stuck", 64'(n_stuck), 64'(exp_stuck));
    check("final_overflow", 64'(n_ovf), 64'(exp_ovf));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
